// File: rtl/dnn_mlp_param.sv
// Two-layer fully connected network (input -> hidden -> output) evaluated
// over several cycles with LANES multiply-accumulate lanes per layer.
// The hidden layer uses ReLU unless bypassed for that vector.
module dnn_mlp_param #(
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 2,
    parameter int XW    = 7,
    parameter int WW    = 5,
    parameter int LANES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_IN*XW-1:0]        x,
    input  logic [N_IN*N_HID*WW-1:0]  w1,
    input  logic [N_HID*N_OUT*WW-1:0] w2,
    input  logic                      relu_bypass,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_OUT*(XW+WW+$clog2(N_IN)+WW+$clog2(N_HID))-1:0] out
);

    localparam int HW   = XW + WW + $clog2(N_IN);
    localparam int OW   = HW + WW + $clog2(N_HID);
    localparam int L1C  = (N_HID + LANES - 1) / LANES;
    localparam int L2C  = (N_OUT + LANES - 1) / LANES;
    localparam int MAXC = (L1C > L2C) ? L1C : L2C;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] L1_LAST = CW'(L1C - 1);
    localparam logic [CW-1:0] L2_LAST = CW'(L2C - 1);

    typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   accept;

    logic signed [XW-1:0]   x_q   [N_IN];
    logic signed [WW-1:0]   w1_q  [N_HID][N_IN];
    logic signed [WW-1:0]   w2_q  [N_OUT][N_HID];
    logic                   byp_q;

    logic signed [HW-1:0]   hid_q [N_HID];
    logic signed [OW-1:0]   out_q [N_OUT];

    logic signed [WW-1:0]   w1sel [LANES][N_IN];
    logic signed [WW-1:0]   w2sel [LANES][N_HID];
    logic signed [HW-1:0]   hsum  [LANES];
    logic signed [OW-1:0]   osum  [LANES];

    // Hidden activation: ReLU clamps negatives to zero unless bypassed.
    function automatic logic signed [HW-1:0] act(input logic signed [HW-1:0] s,
                                                 input logic byp);
        if (!byp && s[HW-1]) return '0;
        return s;
    endfunction

    assign accept = in_valid & in_ready;

    // State register and cycle counter within the current layer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: each layer runs for its ceil(nodes/LANES) cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (in_valid) state_d = L1;
            end
            L1: begin
                if (cnt_q == L1_LAST) begin
                    state_d = L2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            L2: begin
                if (cnt_q == L2_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Operand capture on accept; contents are don't-care outside a vector.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N_IN; i++)
                x_q[i] <= x[i*XW +: XW];
            for (int h = 0; h < N_HID; h++)
                for (int i = 0; i < N_IN; i++)
                    w1_q[h][i] <= w1[(h*N_IN+i)*WW +: WW];
            for (int o = 0; o < N_OUT; o++)
                for (int h = 0; h < N_HID; h++)
                    w2_q[o][h] <= w2[(o*N_HID+h)*WW +: WW];
            byp_q <= relu_bypass;
        end
    end

    // Layer-1 lanes: pick this cycle's weight columns, then dot with x.
    always_comb begin
        for (int l = 0; l < LANES; l++)
            for (int i = 0; i < N_IN; i++)
                w1sel[l][i] = '0;
        for (int h = 0; h < N_HID; h++)
            if (cnt_q == CW'(h / LANES))
                for (int i = 0; i < N_IN; i++)
                    w1sel[h % LANES][i] = w1_q[h][i];
        for (int l = 0; l < LANES; l++) begin
            hsum[l] = '0;
            for (int i = 0; i < N_IN; i++)
                hsum[l] = hsum[l] + HW'(x_q[i]) * HW'(w1sel[l][i]);
        end
    end

    // Layer-2 lanes: pick this cycle's weight columns, then dot with hidden.
    always_comb begin
        for (int l = 0; l < LANES; l++)
            for (int h = 0; h < N_HID; h++)
                w2sel[l][h] = '0;
        for (int o = 0; o < N_OUT; o++)
            if (cnt_q == CW'(o / LANES))
                for (int h = 0; h < N_HID; h++)
                    w2sel[o % LANES][h] = w2_q[o][h];
        for (int l = 0; l < LANES; l++) begin
            osum[l] = '0;
            for (int h = 0; h < N_HID; h++)
                osum[l] = osum[l] + OW'(hid_q[h]) * OW'(w2sel[l][h]);
        end
    end

    // Hidden registers: write the nodes owned by this L1 cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int h = 0; h < N_HID; h++) hid_q[h] <= '0;
        end else if (state_q == L1) begin
            for (int h = 0; h < N_HID; h++)
                if (cnt_q == CW'(h / LANES))
                    hid_q[h] <= act(hsum[h % LANES], byp_q);
        end
    end

    // Output registers: write the nodes owned by this L2 cycle; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < N_OUT; o++) out_q[o] <= '0;
        end else if (state_q == L2) begin
            for (int o = 0; o < N_OUT; o++)
                if (cnt_q == CW'(o / LANES))
                    out_q[o] <= osum[o % LANES];
        end
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_out
        assign out[o*OW +: OW] = out_q[o];
    end

endmodule

// File: doc/dnn_mlp_param.md
DNN_MLP_PARAM -- requirements
Module: dnn_mlp_param

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning input-layer node count.
REQ-002 SHALL have parameter N_HID, default 4, meaning hidden-layer node count.
REQ-003 SHALL have parameter N_OUT, default 2, meaning output node count.
REQ-004 SHALL have parameter XW, default 7, meaning signed input width.
REQ-005 SHALL have parameter WW, default 5, meaning signed weight width.
REQ-006 SHALL have parameter LANES, default 2, meaning nodes computed per cycle; legal range is 1..max(N_HID,N_OUT).
REQ-007 SHALL define derived widths HW = XW+WW+clog2(N_IN) for hidden values and OW = HW+WW+clog2(N_HID) for outputs; with defaults HW=14 and OW=21.
REQ-008 SHALL use one clock and an asynchronous active-low reset, with ports:
  clk  in  1  clock, all flops on the rising edge
  rst_n  in  1  asynchronous active-low reset
  in_valid  in  1  input vector and weights present
  in_ready  out  1  block can accept
  x  in  N_IN*XW  signed inputs, x_i at bits [i*XW +: XW]
  w1  in  N_IN*N_HID*WW  signed layer-1 weights, w1[i][h] at bits [(h*N_IN+i)*WW +: WW]
  w2  in  N_HID*N_OUT*WW  signed layer-2 weights, w2[h][o] at bits [(o*N_HID+h)*WW +: WW]
  relu_bypass  in  1  1 = hidden activation is the identity
  out_valid  out  1  result vector valid
  out_ready  in  1  consumer accepts
  out  out  N_OUT*OW  signed results, out_o at bits [o*OW +: OW]

Function
REQ-009 SHALL implement an FSM with states IDLE, L1, L2 and DONE.
REQ-010 SHALL drive in_ready=1 only in IDLE; an accept occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-011 SHALL, on accept, register x, w1, w2 and relu_bypass, and go IDLE->L1; input ports are don't-care afterwards.
REQ-012 SHALL, in L1, compute hidden nodes h = c*LANES .. c*LANES+LANES-1 in cycle c (c = 0 .. L1C-1, L1C = ceil(N_HID/LANES)); lanes with h >= N_HID are ignored.
REQ-013 SHALL compute each hidden sum as the full-precision signed sum over i of x_i*w1[i][h] (HW bits), then store ReLU(sum) (negative -> 0), or the raw sum when relu_bypass was 1 at accept.
REQ-014 SHALL, in L2, compute outputs o = c*LANES .. in cycle c (c = 0 .. L2C-1, L2C = ceil(N_OUT/LANES)) as the full-precision signed sum over h of hid_h*w2[h][o] (OW bits), registered into out_o; lanes with o >= N_OUT are ignored.
REQ-015 SHALL transition L1->L2 after the L1C-th L1 cycle and L2->DONE after the L2C-th L2 cycle.
REQ-016 SHALL raise out_valid exactly L1C+L2C cycles after the accept edge (defaults: 3 cycles).
REQ-017 SHALL, in DONE, hold out_valid=1 and out stable until out_ready=1 (backpressure of any length); on out_valid&out_ready go DONE->IDLE.
REQ-018 SHALL keep out holding the last result after the handshake, until it is overwritten in L2.
REQ-019 SHALL ignore in_valid in L1, L2 and DONE; there is no overlap between successive vectors.
REQ-020 SHALL be free of arithmetic overflow at any legal parameter set; no saturation or truncation is needed, and the FSM SHALL use no latches.

Reset
REQ-021 SHALL, while rst_n=0, immediately force state=IDLE, out_valid=0, in_ready=1 (as soon as rst_n is released), out=0 and all hidden registers=0.
REQ-022 SHALL, on reset asserted mid-operation (L1/L2/DONE), abandon the vector; no out_valid pulse follows, and the next accept is possible on the first edge after release.

Verification
REQ-023 SHALL cover: defaults, all x=1, all w1=1, all w2=1, bypass=0 -> out_valid 3 cycles after accept, out0=out1=16.
REQ-024 SHALL cover: x all -64, w1 all -16, w2 all -16 -> hidden 4096 each, out0=out1=-262144 (no overflow at OW=21).
REQ-025 SHALL cover: x all 1, w1 all -1, w2 all 1: bypass=0 -> out=0; bypass=1 -> out=-16.
REQ-026 SHALL cover: out_ready held 0 for 5 cycles with in_valid=1 -> out stable, out_valid=1, in_ready=0, no second accept; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-027 SHALL cover: rst_n pulsed low during L1 -> out_valid stays 0, out=0, in_ready=1 after release, next vector correct.
REQ-028 SHALL cover: N_HID=3, N_OUT=3, LANES=2, all x=1, all weights=1 -> latency 4 cycles, every out=12.
